// File: rtl/classification_controller.sv
// rtl/classification_controller.sv - sequencer for one k-means classification pass
//
// Loads k centroids, clears the accumulators, streams sample RAM through the
// two-stage distance pipeline and steers each result to its accumulator.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_centroids,      pass request with centroid count k and last
//   last_addr                  sample address (sampled in IDLE only)
//   hold                       sample RAM unavailable this cycle
//   min_idx                    nearest-centroid index from the datapath
//   ram_rd_en, ram_addr        sample RAM read port
//   ram_input_reg_en,          pipeline stage advances
//   pipe1_en, pipe2_en
//   centroid_en, cen_idx       centroid register load strobe and source select
//   acc_clear                  clear all accumulators and counters
//   accumulators_en,           one-hot accumulate / count of the current point
//   accumulators_cnt_en
//   busy, done, idx_err        status: active, end-of-pass pulse, sticky bad index
module classification_controller #(
    parameter int addrWidth    = 8,
    parameter int centroid_num = 8,
    parameter int idxWidth     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [idxWidth:0]       num_centroids,
    input  logic [addrWidth-1:0]    last_addr,
    input  logic                    hold,
    input  logic [idxWidth-1:0]     min_idx,
    output logic                    ram_rd_en,
    output logic [addrWidth-1:0]    ram_addr,
    output logic                    ram_input_reg_en,
    output logic                    pipe1_en,
    output logic                    pipe2_en,
    output logic [centroid_num-1:0] centroid_en,
    output logic [idxWidth-1:0]     cen_idx,
    output logic                    acc_clear,
    output logic [centroid_num-1:0] accumulators_en,
    output logic [centroid_num-1:0] accumulators_cnt_en,
    output logic                    busy,
    output logic                    done,
    output logic                    idx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CEN,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [idxWidth:0] K_ONE = (idxWidth+1)'(1);
    localparam logic [idxWidth:0] K_MAX = (idxWidth+1)'(centroid_num);

    state_t                state_q, state_d;
    logic [idxWidth:0]     k_q, k_d;
    logic [addrWidth-1:0]  last_q, last_d;
    logic [addrWidth-1:0]  addr_q, addr_d;
    logic [idxWidth-1:0]   j_q, j_d;
    logic [3:0]            s_q, s_d;
    logic                  idx_err_q, idx_err_d;

    logic                  read_issued;
    logic                  acc_hit;
    logic [idxWidth:0]     k_in;

    // Out-of-range counts are folded into 1..centroid_num at capture time.
    assign k_in = (num_centroids == '0)   ? K_ONE :
                  (num_centroids > K_MAX) ? K_MAX : num_centroids;

    assign read_issued = (state_q == S_STREAM) && !hold;

    // s_q[3] marks a real point reaching the accumulate stage this cycle.
    assign acc_hit = s_q[3] && ({1'b0, min_idx} < k_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= K_ONE;
            last_q    <= '0;
            addr_q    <= '0;
            j_q       <= '0;
            s_q       <= '0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            j_q       <= j_d;
            s_q       <= s_d;
            idx_err_q <= idx_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        addr_d    = addr_q;
        j_d       = j_q;
        idx_err_d = idx_err_q;
        s_d       = {s_q[2:0], read_issued};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d       = k_in;
                    last_d    = last_addr;
                    j_d       = '0;
                    idx_err_d = 1'b0;
                    state_d   = S_LOAD_CEN;
                end
            end
            S_LOAD_CEN: begin
                if ({1'b0, j_q} == k_q - K_ONE) begin
                    state_d = S_CLEAR;
                end else begin
                    j_d = j_q + idxWidth'(1);
                end
            end
            S_CLEAR: begin
                addr_d  = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (!hold) begin
                    // Stop on the last address instead of incrementing, so the
                    // address never wraps even when last_addr is all ones.
                    if (addr_q == last_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + addrWidth'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Leaving when only s[3] may be set lets the final accumulate
                // land in this last DRAIN cycle.
                if (s_q[2:0] == 3'b000) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (s_q[3] && !acc_hit) begin
            idx_err_d = 1'b1;
        end
    end

    assign ram_rd_en           = read_issued;
    assign ram_addr            = (state_q == S_STREAM) ? addr_q : '0;
    assign ram_input_reg_en    = s_q[0];
    assign pipe1_en            = s_q[1];
    assign pipe2_en            = s_q[2];
    assign centroid_en         = (state_q == S_LOAD_CEN) ? (centroid_num'(1) << j_q) : '0;
    assign cen_idx             = (state_q == S_LOAD_CEN) ? j_q : '0;
    assign acc_clear           = (state_q == S_CLEAR);
    assign accumulators_en     = acc_hit ? (centroid_num'(1) << min_idx) : '0;
    assign accumulators_cnt_en = accumulators_en;
    assign busy                = (state_q != S_IDLE);
    assign done                = (state_q == S_DONE);
    assign idx_err             = idx_err_q;

endmodule

// File: tb/tb_classification_controller.sv
// tb/tb_classification_controller.sv - self-checking bench for classification_controller
module tb_classification_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] num_centroids = '0;
    logic [7:0] last_addr = '0;
    logic       hold = 1'b0;
    logic [2:0] min_idx = '0;
    logic       ram_rd_en, ram_input_reg_en, pipe1_en, pipe2_en;
    logic [7:0] ram_addr, centroid_en, accumulators_en, accumulators_cnt_en;
    logic [2:0] cen_idx;
    logic       acc_clear, busy, done, idx_err;

    classification_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_centroids(num_centroids),
        .last_addr(last_addr), .hold(hold), .min_idx(min_idx),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_input_reg_en(ram_input_reg_en),
        .pipe1_en(pipe1_en), .pipe2_en(pipe2_en), .centroid_en(centroid_en),
        .cen_idx(cen_idx), .acc_clear(acc_clear), .accumulators_en(accumulators_en),
        .accumulators_cnt_en(accumulators_cnt_en), .busy(busy), .done(done),
        .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    // bit 42 busy, 41 done, 40 idx_err, 39 acc_clear, 38 rd_en, 37:30 addr,
    // 29 in_reg, 28 pipe1, 27 pipe2, 26:19 centroid_en, 18:16 cen_idx,
    // 15:8 accumulators_en, 7:0 accumulators_cnt_en
    logic [42:0] obs_now;
    assign obs_now = {busy, done, idx_err, acc_clear, ram_rd_en, ram_addr,
                      ram_input_reg_en, pipe1_en, pipe2_en, centroid_en, cen_idx,
                      accumulators_en, accumulators_cnt_en};

    localparam int N = 2048;

    int checks = 0;
    int failures = 0;

    logic        hold_v [0:N-1];
    logic [2:0]  min_v  [0:N-1];
    logic [42:0] obs_v  [0:N-1];
    logic [42:0] exp_v  [0:N-1];
    logic [42:0] abort_obs;

    logic [3:0]  k_req;
    int          last_req;
    bit          restart_en;
    bit          b2b;
    int          abort_rel;
    int          n_cyc;
    int          done_c;
    logic        model_err = 1'b0;

    task automatic setup_pass(input int k, input int last, input int pct, input bit rs);
        k_req      = 4'(k);
        last_req   = last;
        restart_en = rs;
        b2b        = 1'b0;
        abort_rel  = 0;
        for (int c = 0; c < N; c++) begin
            hold_v[c] = ($urandom_range(0, 99) < pct);
            min_v[c]  = 3'($urandom_range(0, 7));
        end
    endtask

    // Expected per-cycle outputs come from a cycle schedule of the pass:
    // k load cycles, one clear, reads on non-held cycles, each read retiring
    // four cycles later, done one cycle after the last retire.
    task automatic run_pass();
        logic       e_busy [0:N-1];
        logic       e_done [0:N-1];
        logic       e_err  [0:N-1];
        logic       e_clr  [0:N-1];
        logic       e_rd   [0:N-1];
        logic [7:0] e_addr [0:N-1];
        logic       e_inr  [0:N-1];
        logic       e_p1   [0:N-1];
        logic       e_p2   [0:N-1];
        logic [7:0] e_cen  [0:N-1];
        logic [2:0] e_cidx [0:N-1];
        logic [7:0] e_acc  [0:N-1];
        int reads[$];
        int keff, kk, a, c, last_rd, first_bad, abort_c;
        for (int i = 0; i < N; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_clr[i] = 0; e_rd[i] = 0;
            e_addr[i] = 0; e_inr[i] = 0; e_p1[i] = 0; e_p2[i] = 0; e_cen[i] = 0;
            e_cidx[i] = 0; e_acc[i] = 0;
        end
        kk   = int'(k_req);
        keff = (kk == 0) ? 1 : ((kk > 8) ? 8 : kk);
        for (int j = 1; j <= keff; j++) begin
            e_cen[j]  = 8'd1 << (j - 1);
            e_cidx[j] = 3'(j - 1);
        end
        e_clr[keff + 1] = 1'b1;
        a = 0;
        c = keff + 2;
        while (c < N - 16) begin
            e_addr[c] = 8'(a);
            if (!hold_v[c]) begin
                e_rd[c] = 1'b1;
                reads.push_back(c);
                if (a == last_req) break;
                a++;
            end
            c++;
        end
        last_rd   = c;
        done_c    = last_rd + 5;
        n_cyc     = b2b ? done_c + 1 : done_c + 2;
        first_bad = N;
        foreach (reads[i]) begin
            e_inr[reads[i] + 1] = 1'b1;
            e_p1[reads[i] + 2]  = 1'b1;
            e_p2[reads[i] + 3]  = 1'b1;
            if (int'(min_v[reads[i] + 4]) < keff)
                e_acc[reads[i] + 4] = 8'd1 << min_v[reads[i] + 4];
            else if (reads[i] + 5 < first_bad)
                first_bad = reads[i] + 5;
        end
        for (int j = 1; j <= done_c; j++) e_busy[j] = 1'b1;
        e_done[done_c] = 1'b1;
        e_err[0] = model_err;
        for (int j = 1; j < n_cyc; j++) e_err[j] = (j >= first_bad);
        abort_c = (abort_rel > 0) ? last_rd + abort_rel : -1;

        for (int j = 0; j < n_cyc; j++) begin
            @(posedge clk);
            #1;
            start         = (j == 0) ? 1'b1 :
                            (restart_en && j < done_c && $urandom_range(0, 2) == 0);
            num_centroids = (j == 0) ? k_req : 4'($urandom_range(0, 15));
            last_addr     = (j == 0) ? 8'(last_req) : 8'($urandom);
            hold          = hold_v[j];
            min_idx       = min_v[j];
            #3;
            obs_v[j] = obs_now;
            exp_v[j] = {e_busy[j], e_done[j], e_err[j], e_clr[j], e_rd[j], e_addr[j],
                        e_inr[j], e_p1[j], e_p2[j], e_cen[j], e_cidx[j], e_acc[j], e_acc[j]};
            if (j == abort_c) begin
                rst_n = 1'b0;
                #1;
                abort_obs = obs_now;
                n_cyc = j + 1;
                break;
            end
        end
        model_err = e_err[n_cyc - 1];
        start = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_now !== 43'd0) begin
            failures++;
            $display("FAIL reset_hold got %h expected %h", obs_now, 43'd0);
        end
        rst_n = 1'b1;
        model_err = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_now !== 43'd0) begin
            failures++;
            $display("FAIL reset_release got %h expected %h", obs_now, 43'd0);
        end
    endtask

    task automatic test_basic();
        setup_pass(3, 4, 0, 1'b0);
        for (int c = 0; c < N; c++) min_v[c] = 3'(c % 3);
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL basic cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[14][41] !== 1'b1 || obs_v[15][42] !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_c14 got done=%b busy15=%b expected 1 0",
                     obs_v[14][41], obs_v[15][42]);
        end
    endtask

    task automatic test_hold();
        setup_pass(3, 4, 0, 1'b0);
        hold_v[6] = 1'b1;
        hold_v[7] = 1'b1;
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL hold cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[16][41] !== 1'b1 || obs_v[8][38] !== 1'b1 || obs_v[8][37:30] !== 8'd1) begin
            failures++;
            $display("FAIL hold_timing got done16=%b rd8=%b addr8=%0d expected 1 1 1",
                     obs_v[16][41], obs_v[8][38], obs_v[8][37:30]);
        end
    endtask

    task automatic test_idx_err();
        setup_pass(3, 4, 0, 1'b0);
        min_v[9] = 3'd2; min_v[10] = 3'd0; min_v[11] = 3'd7; min_v[12] = 3'd2; min_v[13] = 3'd1;
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL idx_err cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[11][40] !== 1'b0 || obs_v[12][40] !== 1'b1 || obs_v[15][40] !== 1'b1
            || obs_v[11][15:8] !== 8'd0 || obs_v[13][15:8] !== 8'b010) begin
            failures++;
            $display("FAIL idx_err_points got err11=%b err12=%b err15=%b acc11=%b acc13=%b",
                     obs_v[11][40], obs_v[12][40], obs_v[15][40], obs_v[11][15:8], obs_v[13][15:8]);
        end
        setup_pass(3, 1, 0, 1'b0);
        run_pass();
        checks++;
        if (obs_v[0][40] !== 1'b1 || obs_v[1][40] !== 1'b0) begin
            failures++;
            $display("FAIL idx_err_clear got err0=%b err1=%b expected 1 0",
                     obs_v[0][40], obs_v[1][40]);
        end
    endtask

    task automatic test_single_read();
        setup_pass(8, 0, 0, 1'b0);
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL single_read cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (obs_v[9][39] !== 1'b1 || obs_v[15][41] !== 1'b1) begin
            failures++;
            $display("FAIL single_read_timing got clr9=%b done15=%b expected 1 1",
                     obs_v[9][39], obs_v[15][41]);
        end
    endtask

    task automatic test_restart_ignored();
        for (int p = 0; p < 3; p++) begin
            setup_pass(int'($urandom_range(1, 8)), int'($urandom_range(2, 12)), 20, 1'b1);
            run_pass();
            for (int c = 0; c < n_cyc; c++) begin
                checks++;
                if (obs_v[c] !== exp_v[c]) begin
                    failures++;
                    $display("FAIL restart_ignored pass %0d cycle %0d got %h expected %h",
                             p, c, obs_v[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        setup_pass(2, 5, 0, 1'b0);
        abort_rel = 2;
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL drain_prefix cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
        checks++;
        if (abort_obs !== 43'd0) begin
            failures++;
            $display("FAIL drain_reset got %h expected %h", abort_obs, 43'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_err = 1'b0;
        setup_pass(4, 6, 10, 1'b0);
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL after_reset cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_k_clamp();
        int kv[4] = '{0, 9, 15, 1};
        foreach (kv[i]) begin
            setup_pass(kv[i], int'($urandom_range(3, 10)), 15, 1'b0);
            run_pass();
            for (int c = 0; c < n_cyc; c++) begin
                checks++;
                if (obs_v[c] !== exp_v[c]) begin
                    failures++;
                    $display("FAIL k_clamp k=%0d cycle %0d got %h expected %h",
                             kv[i], c, obs_v[c], exp_v[c]);
                end
            end
        end
    endtask

    task automatic test_no_wrap();
        setup_pass(5, 255, 0, 1'b0);
        run_pass();
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                failures++;
                $display("FAIL no_wrap cycle %0d got %h expected %h", c, obs_v[c], exp_v[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            setup_pass(int'($urandom_range(0, 15)), int'($urandom_range(0, 30)),
                       int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
            b2b = 1'b1;
            run_pass();
            for (int c = 0; c < n_cyc; c++) begin
                checks++;
                if (obs_v[c] !== exp_v[c]) begin
                    failures++;
                    $display("FAIL back_to_back pass %0d cycle %0d got %h expected %h",
                             p, c, obs_v[c], exp_v[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_idx_err();
        test_single_read();
        test_restart_ignored();
        test_reset_mid_drain();
        test_k_clamp();
        test_no_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/classification_controller.md
Name: classification_controller

Overview:
- Sequencer for one classification pass of the k-means classification datapath.
- Loads the active centroids and clears the accumulators, then streams every data point from sample RAM through the two-stage distance pipeline.
- Steers each point's nearest-centroid result into the matching accumulator and counter.
- Signals completion to the k-means core's top-level control.

Parameters:
addrWidth, 8, sample-RAM address width
centroid_num, 8, maximum number of centroids (width of per-centroid enable vectors)
idxWidth, 3, width of a centroid index (must equal clog2(centroid_num))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
num_centroids  in  idxWidth+1  active centroid count k, legal 1..centroid_num; sampled with start
last_addr  in  addrWidth  address of last data point; sampled with start
hold  in  1  RAM not available; suppresses read issue this cycle
min_idx  in  idxWidth  argmin centroid index from datapath, valid in the accumulate stage
ram_rd_en  out  1  read strobe to sample RAM
ram_addr  out  addrWidth  read address
ram_input_reg_en  out  1  load RAM output register
pipe1_en  out  1  advance distance stage 1
pipe2_en  out  1  advance distance stage 2
centroid_en  out  centroid_num  one-hot centroid register load
cen_idx  out  idxWidth  index of centroid being loaded (source select)
acc_clear  out  1  synchronous clear of all accumulators and counters
accumulators_en  out  centroid_num  one-hot accumulate of current point
accumulators_cnt_en  out  centroid_num  one-hot counter increment, identical to accumulators_en
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at pass end
idx_err  out  1  sticky: min_idx >= k seen in accumulate stage

Behaviour:
- Reset (async, any time, including mid-pass):
  - FSM goes to IDLE; stage-valid shifter s[3:0] = 0; all outputs 0; idx_err = 0.
  - In-flight points are discarded.
- States: IDLE, LOAD_CEN, CLEAR, STREAM, DRAIN, DONE. Controls are registered outputs of state/counters.
- IDLE:
  - start=1 latches k and last_addr, clears idx_err, and moves to LOAD_CEN.
  - start in any other state is ignored.
  - k=0 is treated as 1; k>centroid_num is treated as centroid_num.
- LOAD_CEN:
  - Runs k cycles. Cycle j drives centroid_en = 1<<j and cen_idx = j.
  - Moves to CLEAR after j = k-1.
- CLEAR: one cycle with acc_clear=1, then STREAM at address 0.
- STREAM:
  - Each cycle with hold=0: ram_rd_en=1, ram_addr=current address, then address increments.
  - Cycles with hold=1: ram_rd_en=0, address holds, bubble enters the pipe.
  - After the read of last_addr, move to DRAIN. Address never wraps.
  - last_addr=0 gives exactly one read.
- Pipeline, with s <= {s[2:0], read_issued} every cycle:
  - A read issued in cycle c gives ram_input_reg_en at c+1, pipe1_en at c+2, pipe2_en at c+3, accumulate at c+4.
  - Bubbles produce no enables.
- Accumulate:
  - When s[3]=1 and min_idx<k: accumulators_en = accumulators_cnt_en = 1<<min_idx. These are combinational from registered s[3] and the min_idx input.
  - When min_idx>=k: no enable, idx_err sets and stays set until the next accepted start.
- DRAIN: when s[2:0]==0, move to DONE next cycle, so the last accumulate completes in the final DRAIN cycle.
- DONE: done=1 for one cycle, then IDLE. busy=0 from IDLE.
- acc_clear, centroid_en and accumulate enables are never asserted in the same cycle.

Test Plan:
1. Reset, k=3, last_addr=4, start high in C0, hold=0:
   - C1–C3: centroid_en = 001, 010, 100.
   - C4: acc_clear.
   - C5–C9: reads at addr 0–4.
   - C13: last accumulate.
   - C14: done=1. C15: busy=0.
2. Same run with hold=1 in C6 and C7:
   - No reads in C6–C7; addr 1 is read in C8 and the last read is in C11.
   - Enables show the 2-cycle gap; done moves to C16.
3. min_idx sequence 2,0,7,2,1 with k=3:
   - accumulators_en = 100, 001, 000, 100, 010 at C9–C13.
   - idx_err=1 from C12 and stays high after done.
   - The next start clears idx_err.
4. last_addr=0, k=8:
   - LOAD_CEN lasts 8 cycles, then exactly one read and one accumulate.
   - done appears 6 cycles after CLEAR.
5. Re-assert start during STREAM: ignored, with no address, state or k change. Assert rst_n=0 mid-DRAIN: all outputs 0 immediately; the next start runs a clean pass.
6. k=0 and k=9 (num_centroids is 4 bits): behave as k=1 and k=8 respectively in LOAD_CEN length and the idx_err threshold.
